// File: rtl/console_input_pkg.sv
// Shared peripheral constants for the console input device.
//   - Address window of the device in the peripheral map (decoded upstream).
//   - Serial timing derived from the system clock and the console baud rate.
//   - Register word offsets and the helper that packs the STATUS word.
package console_input_pkg;

  localparam logic [31:0] console_base_addr = 32'h0100_0008;
  localparam logic [31:0] console_top_addr  = 32'h0100_0010;

  localparam int unsigned clk_freq  = 1_000_000_000;
  localparam int unsigned baud_rate = 1_152_000;
  localparam int unsigned console_clks_per_bit = clk_freq / baud_rate;

  // Register word offsets, taken from mem_addr[3:2]
  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_RSVD0  = 2'd2,
    REG_RSVD1  = 2'd3
  } reg_off_t;

  localparam logic [31:0] DATA_EMPTY_WORD = 32'h8000_0000;

  function automatic logic [31:0] pack_status(input logic       overrun,
                                              input logic       frame_err,
                                              input logic       irq_en,
                                              input logic [7:0] count);
    return {16'h0000, count, 5'b00000, irq_en, frame_err, overrun};
  endfunction

endpackage

// File: rtl/console_rx_fifo.sv
// Synchronous byte FIFO for received console characters.
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_push, i_push_data   write request and byte
//   i_pop                 read request (ignored when empty)
//   o_head                byte at the read pointer (valid when not empty)
//   o_full, o_empty       occupancy flags
//   o_count               number of stored entries
//   o_overflow            a push was dropped because the FIFO was full
module console_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [7:0]               i_push_data,
  input  logic                     i_pop,
  output logic [7:0]               o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_do_push;
  logic        w_do_pop;

  // Extra pointer bit distinguishes full from empty; subtraction wraps naturally.
  assign o_count = r_wptr - r_rptr;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (o_count == (AW+1)'(DEPTH));
  assign o_head  = r_mem[r_rptr[AW-1:0]];

  assign w_do_pop   = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_do_push  = i_push & (~o_full | w_do_pop);
  assign o_overflow = i_push & o_full & ~w_do_pop;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/console_input.sv
// Memory-mapped console input: 8N1 serial receiver feeding a byte FIFO,
// read by the core over the mem_* responder handshake.
// Ports:
//   reset, clock     synchronous active-low reset, system clock
//   mem_valid        request strobe, held until mem_ready
//   mem_instr        instruction fetch flag (handled as a read)
//   mem_addr         byte address; only [3:2] is decoded (window decoded upstream)
//   mem_wdata        write data
//   mem_wstrb        byte strobes; zero means read
//   mem_rdata        read data, valid with mem_ready
//   mem_ready        one-cycle response pulse, one cycle after acceptance
//   rx               serial input, idle high, asynchronous
//   irq              level interrupt: FIFO non-empty and irq enabled
// Registers (word offset): 0 DATA, 1 STATUS, 2/3 reserved (read 0).
module console_input
  import console_input_pkg::*;
#(
  parameter int clks_per_bit = console_clks_per_bit,
  parameter int buffer_depth = 16
) (
  input  logic        reset,
  input  logic        clock,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  input  logic        rx,
  output logic        irq
);

  localparam int CW = $clog2(clks_per_bit);
  localparam int AW = $clog2(buffer_depth);
  localparam logic [CW-1:0] HALF_M1 = CW'(clks_per_bit / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(clks_per_bit - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;

  // Receiver
  logic          r_rx_meta;
  logic          r_rx_sync;
  logic          r_rx_prev;
  rx_state_t     r_state;
  rx_state_t     w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [2:0]    r_bits;
  logic [2:0]    w_bits_next;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_next;
  logic          w_cnt_zero;
  logic          w_push;
  logic          w_frame_set;

  // FIFO
  logic [7:0]    w_head;
  logic          w_full;
  logic          w_empty;
  logic [AW:0]   w_count;
  logic          w_overflow;

  // Bus and status
  logic          w_accept;
  logic          w_is_read;
  reg_off_t      w_off;
  logic          w_pop;
  logic          w_status_wr;
  logic [31:0]   w_rdata;
  logic          r_ready;
  logic [31:0]   r_rdata;
  logic          r_overrun;
  logic          r_frame_err;
  logic          r_irq_en;
  logic          r_irq;
  logic          w_unused_bits;

  // ---- rx synchroniser and edge history; reset to idle-high ----
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_cnt_zero = (r_cnt == '0);

  // ---- RX FSM state register ----
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bits  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bits  <= w_bits_next;
    end
  end

  always_ff @(posedge clock) begin
    r_shift <= w_shift_next;
  end

  // ---- RX FSM next state; counter reload points land mid-bit ----
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bits_next  = r_bits;
    w_shift_next = r_shift;
    w_push       = 1'b0;
    w_frame_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_rx_prev && !r_rx_sync) begin
          w_cnt_next   = HALF_M1;
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (w_cnt_zero) begin
          if (!r_rx_sync) begin
            w_cnt_next   = FULL_M1;
            w_bits_next  = '0;
            w_state_next = ST_DATA;
          end else begin
            // Line went back high before mid start bit: glitch.
            w_state_next = ST_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      ST_DATA: begin
        if (w_cnt_zero) begin
          w_shift_next = {r_rx_sync, r_shift[7:1]};
          w_bits_next  = r_bits + 3'd1;
          w_cnt_next   = FULL_M1;
          if (r_bits == 3'd7) w_state_next = ST_STOP;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      ST_STOP: begin
        if (w_cnt_zero) begin
          if (r_rx_sync) w_push      = 1'b1;
          else           w_frame_set = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  console_rx_fifo #(
    .DEPTH(buffer_depth)
  ) u_fifo (
    .i_clk       (clock),
    .i_rst_n     (reset),
    .i_push      (w_push),
    .i_push_data (r_shift),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count),
    .o_overflow  (w_overflow)
  );

  // ---- bus decode; no acceptance during the response cycle ----
  assign w_accept    = mem_valid & ~r_ready;
  assign w_is_read   = mem_instr | (mem_wstrb == 4'b0000);
  assign w_off       = reg_off_t'(mem_addr[3:2]);
  assign w_pop       = w_accept & w_is_read & (w_off == REG_DATA) & ~w_empty;
  assign w_status_wr = w_accept & ~w_is_read & (w_off == REG_STATUS) & mem_wstrb[0];

  // Status reflects pre-edge state, so a same-cycle push is not yet counted.
  always_comb begin
    w_rdata = '0;
    if (w_accept && w_is_read) begin
      case (w_off)
        REG_DATA:   w_rdata = w_empty ? DATA_EMPTY_WORD : {24'h0, w_head};
        REG_STATUS: w_rdata = pack_status(r_overrun, r_frame_err, r_irq_en, 8'(w_count));
        default:    w_rdata = '0;
      endcase
    end
  end

  // ---- response and status registers ----
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ready     <= 1'b0;
      r_rdata     <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_irq_en    <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_ready     <= w_accept;
      r_rdata     <= w_rdata;
      // Set terms OR'd last so a new event wins over a same-cycle clear.
      r_overrun   <= (r_overrun   & ~(w_status_wr & mem_wdata[0])) | w_overflow;
      r_frame_err <= (r_frame_err & ~(w_status_wr & mem_wdata[1])) | w_frame_set;
      r_irq_en    <= r_irq_en | (w_status_wr & mem_wdata[2]);
      r_irq       <= r_irq_en & ~w_empty;
    end
  end

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;
  assign irq       = r_irq;

  assign w_unused_bits = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:3],
                           mem_wstrb[3:1], w_full};

endmodule

// File: tb/tb_console_input.sv
module tb_console_input;

  localparam int CPB   = 8;
  localparam int DEPTH = 16;

  logic        reset;
  logic        clock;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        rx;
  logic        irq;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  mdl_q[$];
  logic        mdl_ovr = 1'b0;
  logic        mdl_fe  = 1'b0;
  logic        mdl_ien = 1'b0;
  logic        irq_at_ready;

  console_input #(
    .clks_per_bit(CPB),
    .buffer_depth(DEPTH)
  ) dut (
    .reset     (reset),
    .clock     (clock),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .rx        (rx),
    .irq       (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one 8N1 frame; the model is updated once the stop bit is over.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clock);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    if (!stop)                       mdl_fe  = 1'b1;
    else if (mdl_q.size() >= DEPTH)  mdl_ovr = 1'b1;
    else                             mdl_q.push_back(b);
  endtask

  task automatic bus(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input logic instr);
    logic        is_rd;
    logic [31:0] e;
    int          waited;
    is_rd = instr || (wstrb == 4'b0000);
    if (is_rd) begin
      case (addr[3:2])
        2'd0:    e = (mdl_q.size() == 0) ? 32'h8000_0000 : {24'h0, mdl_q.pop_front()};
        2'd1:    e = {16'h0, 8'(mdl_q.size()), 5'h0, mdl_ien, mdl_fe, mdl_ovr};
        default: e = 32'h0;
      endcase
      exp_q.push_back(e);
    end else if (addr[3:2] == 2'd1 && wstrb[0]) begin
      if (wdata[0]) mdl_ovr = 1'b0;
      if (wdata[1]) mdl_fe  = 1'b0;
      if (wdata[2]) mdl_ien = 1'b1;
    end
    @(negedge clock);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    mem_instr = instr;
    @(posedge clock);
    #1;
    mem_valid = 1'b0;
    mem_wstrb = 4'b0000;
    mem_instr = 1'b0;
    waited = 0;
    while (!mem_ready && waited < 4) begin
      @(posedge clock);
      #1;
      waited++;
    end
    irq_at_ready = irq;
    check({tag, "_ready"}, {31'h0, mem_ready}, 32'h1);
    check({tag, "_lat"}, waited, 32'h0);
    if (is_rd) begin
      e = exp_q.pop_front();
      check({tag, "_rdata"}, mem_rdata, e);
    end
    @(posedge clock);
    #1;
    check({tag, "_pulse"}, {31'h0, mem_ready}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    rx        = 1'b1;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    repeat (4) @(negedge clock);
    check("rst_ready", {31'h0, mem_ready}, 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    bus("rst_status", 32'h4, 32'h0, 4'h0, 1'b0);

    // Single byte, then empty read, fetch-pop, reserved offsets
    send_byte(8'h55, 1'b1);
    bus("data55", 32'h0, 32'h0, 4'h0, 1'b0);
    bus("data_empty", 32'h0, 32'h0, 4'h0, 1'b0);
    send_byte(8'h3C, 1'b1);
    bus("fetch3c", 32'h0, 32'h0, 4'h0, 1'b1);
    bus("rsvd8_wr", 32'h8, 32'hFFFF_FFFF, 4'hF, 1'b0);
    bus("rsvd8", 32'h8, 32'h0, 4'h0, 1'b0);
    bus("rsvdc", 32'hC, 32'h0, 4'h0, 1'b0);
    bus("data_wr_ign", 32'h0, 32'h0000_00AA, 4'h1, 1'b0);
    bus("data_empty2", 32'h0, 32'h0, 4'h0, 1'b0);

    // Overflow: 17 bytes into a 16-entry FIFO
    for (int i = 0; i <= 16; i++) send_byte(8'(i), 1'b1);
    bus("ovr_status", 32'h4, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 16; i++) bus("ovr_data", 32'h0, 32'h0, 4'h0, 1'b0);
    bus("ovr_empty", 32'h0, 32'h0, 4'h0, 1'b0);
    bus("ovr_clr", 32'h4, 32'h1, 4'h1, 1'b0);
    bus("ovr_status2", 32'h4, 32'h0, 4'h0, 1'b0);

    // Framing error and its W1C clear
    send_byte(8'hA3, 1'b0);
    bus("fe_status", 32'h4, 32'h0, 4'h0, 1'b0);
    bus("fe_clr", 32'h4, 32'h2, 4'h1, 1'b0);
    bus("fe_status2", 32'h4, 32'h0, 4'h0, 1'b0);

    // Short low glitch is rejected and the receiver is ready again quickly
    @(negedge clock);
    rx = 1'b0;
    repeat (2) @(negedge clock);
    rx = 1'b1;
    repeat (CPB / 2 + 3) @(negedge clock);
    send_byte(8'h96, 1'b1);
    bus("glitch_status", 32'h4, 32'h0, 4'h0, 1'b0);
    bus("glitch_data", 32'h0, 32'h0, 4'h0, 1'b0);

    // Interrupt enable and level behaviour
    bus("ien_wr", 32'h4, 32'h4, 4'h1, 1'b0);
    check("irq_idle", {31'h0, irq}, 32'h0);
    send_byte(8'h41, 1'b1);
    check("irq_rise", {31'h0, irq}, 32'h1);
    bus("irq_data", 32'h0, 32'h0, 4'h0, 1'b0);
    check("irq_hold", {31'h0, irq_at_ready}, 32'h1);
    check("irq_fall", {31'h0, irq}, 32'h0);

    // Reset in the middle of a frame
    @(negedge clock);
    rx = 1'b0;
    repeat (CPB + 3 * CPB) @(negedge clock);
    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    mdl_q.delete();
    mdl_ovr = 1'b0;
    mdl_fe  = 1'b0;
    mdl_ien = 1'b0;
    check("rst2_irq", {31'h0, irq}, 32'h0);
    repeat (2) @(negedge clock);
    send_byte(8'h7E, 1'b1);
    bus("rst2_status", 32'h4, 32'h0, 4'h0, 1'b0);
    bus("rst2_data", 32'h0, 32'h0, 4'h0, 1'b0);
    bus("rst2_empty", 32'h0, 32'h0, 4'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/console_input.md
Name: console_input

Overview:
- Memory-mapped console input device: the read-direction counterpart to the write-only print sink.
- Deserialises an 8N1 serial RX line, buffers received bytes in a FIFO, and answers core loads/stores on the standard mem_* responder handshake.
- Sits beside print and clint in the peripheral address map at base 32'h1000008 (top 32'h1000010), decoded upstream.

Parameters:
- clks_per_bit, 868: clock cycles per serial bit (1 GHz / 1.152 MBd); must be >= 4.
- buffer_depth, 16: FIFO entries; power of two, >= 2.

Ports:
- reset  in  1  synchronous active-low reset
- clock  in  1  system clock
- mem_valid  in  1  request strobe, held until mem_ready
- mem_instr  in  1  instruction fetch flag; treated as a read
- mem_addr  in  32  byte address; only bits [3:2] decoded
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte strobes; all zero means read
- mem_rdata  out  32  read data, valid when mem_ready=1
- mem_ready  out  1  one-cycle response pulse
- rx  in  1  serial input, idle high, asynchronous to clock
- irq  out  1  level interrupt: FIFO non-empty and irq enabled

Behaviour:
- Reset (reset=0 at a clock edge):
  - mem_ready=0, mem_rdata=0, irq=0.
  - FIFO empty; overrun=0, frame_err=0, irq_en=0.
  - RX FSM returns to IDLE, including mid-frame; the partial byte is discarded.
- rx passes through a 2-flop synchroniser before use.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a synchronised falling edge (1 then 0) loads the counter with clks_per_bit/2-1 and moves to START.
  - START: at counter 0, if rx=0 reload clks_per_bit-1 and go to DATA; else treat as a glitch and go to IDLE.
  - DATA: sample at each counter 0, LSB first, into the shift register; after 8 samples go to STOP with counter clks_per_bit-1.
  - STOP: at counter 0, if rx=1 push the byte, else set frame_err and drop the byte; go to IDLE in both cases.
- FIFO push:
  - If full at push time, drop the byte and set overrun (sticky).
  - A push and a pop in the same cycle on a full FIFO are both performed; no overrun.
  - Pointers are log2(buffer_depth)+1 bits and wrap naturally; count = wptr - rptr.
- Bus response:
  - One cycle of latency: a request accepted at edge N gives mem_ready=1 and mem_rdata in the cycle after N, for exactly one cycle.
  - No new request is accepted in the mem_ready cycle.
- Register map (word offset):
  - 0x0 DATA, read: bit31 = empty, bits[7:0] = head byte, other bits 0. A read with the FIFO non-empty pops one entry. A read when empty returns 32'h80000000 and does not pop. Writes are ignored.
  - 0x4 STATUS, read: bit0 overrun, bit1 frame_err, bit2 irq_en, bits[15:8] count. Write with wstrb[0]=1: bits 0 and 1 are write-1-to-clear, bit2 sets irq_en.
  - 0x8 and 0xC: reads return 0, writes are ignored. Both still complete with mem_ready.
- Simultaneous events:
  - A STATUS read in the same cycle as a push returns the pre-push count.
  - A W1C in the same cycle as a new overrun or frame error leaves the flag set (set wins).
- irq = irq_en & ~empty, registered, so it lags FIFO state by 1 cycle.
- Instruction fetches read like data; a fetch at DATA pops.

Decomposition:
- Shared package (the same package as the peripheral constants): console_base_addr=32'h1000008, console_top_addr=32'h1000010, clks_per_bit computed from clk_freq and a new baud_rate parameter, and register offset constants.
- RX FSM state enum lives in the module.
- One sub-module: console_rx_fifo (synchronous FIFO with push/pop/full/empty/count).

Test Plan:
- clks_per_bit=8. Drive 0x55 with a valid stop bit, then read DATA: mem_rdata=32'h00000055 one cycle after the request. A second read returns 32'h80000000.
- Send 17 bytes 0x00..0x10 with no reads (buffer_depth=16). STATUS reads 0x00001001 (count 16, overrun). DATA reads return 0x00..0x0F in order, then empty.
- Send 0xA3 with stop bit 0: STATUS bit1=1 and count=0. Write STATUS 0x2: reads 0x0.
- Drive a 2-cycle low glitch on rx: nothing is received and the FSM is back in IDLE within clks_per_bit/2+3 cycles.
- Write STATUS 0x4, then send 0x41: irq rises after the stop-bit push and falls 2 cycles after the DATA read that pops 0x41.
- Assert reset mid-byte (during DATA state), release it, then send 0x7E: only 0x7E is present and all status flags are 0.
